// File: rtl/serial_master_p.sv
// Parametrised single-wire half-duplex serial master: sends {START, data, csum} LSB first,
// then waits for a 32-bit {START, addr, status, rcsum} response, with retry and timeout.
module serial_master_p #(
  parameter int         DATA_W      = 16,
  parameter logic [7:0] START_BYTE  = 8'hAA,
  parameter logic [7:0] MASTER_ADDR = 8'h00,
  parameter int         TURNAROUND  = 1,
  parameter int         TIMEOUT     = 64,
  parameter int         MAX_RETRY   = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  inout  logic                               serial,
  input  logic                               CS,
  input  logic [DATA_W-1:0]                  mem_read,
  output logic                               r,
  output logic                               ready,
  output logic                               ok,
  output logic                               fail,
  output logic                               checkerr,
  output logic                               noAnswer,
  output logic                               busy,
  output logic [$clog2(MAX_RETRY+2)-1:0]     attempt
);

  localparam int          FW        = DATA_W + 16;
  localparam int          AW        = $clog2(MAX_RETRY + 2);
  localparam logic [31:0] SEND_LAST = 32'(FW - 1);
  localparam logic [31:0] TURN_LAST = 32'(TURNAROUND - 1);
  localparam logic [31:0] RECV_LAST = 32'(TIMEOUT - 1);
  localparam logic [AW-1:0] ATT_MAX = AW'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    TURN,
    RECV,
    CHECK
  } state_t;

  state_t          state, state_d;
  logic [FW-1:0]   frame;
  logic [FW-1:0]   frame_sh;
  logic            tx_bit;
  logic [31:0]     cnt;
  logic [31:0]     window, window_d;
  logic [5:0]      bits_seen, bits_d;
  logic            timeout_flag;
  logic            match, rx_done;
  logic [7:0]      load_csum;
  logic [7:0]      rcsum_exp;
  logic            res_ok, res_fail, res_cerr, res_noans;
  logic            finish;

  function automatic logic [7:0] byte_sum(input logic [DATA_W-1:0] d);
    logic [7:0] s;
    s = '0;
    for (int unsigned i = 0; i < DATA_W / 8; i++) begin
      s = s + d[i*8 +: 8];
    end
    return s;
  endfunction

  // Line is only driven while sending; otherwise the slave owns it.
  assign serial = (state == SEND) ? tx_bit : 1'bz;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d   = state;
    window_d  = {serial, window[31:1]};
    bits_d    = bits_seen[5] ? bits_seen : bits_seen + 6'd1;
    match     = bits_d[5] && (window_d[31:24] == START_BYTE) &&
                (window_d[23:16] == MASTER_ADDR);
    rx_done   = match || (cnt == RECV_LAST);
    frame_sh  = frame >> (cnt + 32'd1);
    load_csum = byte_sum(mem_read);
    rcsum_exp = window[23:16] + window[15:8];

    res_ok    = 1'b0;
    res_fail  = 1'b0;
    res_cerr  = 1'b0;
    res_noans = 1'b0;
    if (timeout_flag) begin
      res_noans = 1'b1;
    end else if (window[7:0] != rcsum_exp) begin
      res_cerr = 1'b1;
    end else if (window[15:8] == 8'h01) begin
      res_ok = 1'b1;
    end else if (window[15:8] == 8'h00) begin
      res_fail = 1'b1;
    end else begin
      res_noans = 1'b1;
    end
    finish = res_ok || res_fail || (attempt == ATT_MAX);

    case (state)
      IDLE:    if (CS) state_d = LOAD;
      LOAD:    state_d = SEND;
      SEND:    if (cnt == SEND_LAST) state_d = TURN;
      TURN:    if (cnt == TURN_LAST) state_d = RECV;
      RECV:    if (rx_done) state_d = CHECK;
      CHECK:   state_d = finish ? IDLE : SEND;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r            <= 1'b0;
      ready        <= 1'b0;
      ok           <= 1'b0;
      fail         <= 1'b0;
      checkerr     <= 1'b0;
      noAnswer     <= 1'b0;
      busy         <= 1'b0;
      attempt      <= '0;
      tx_bit       <= 1'b0;
      cnt          <= '0;
      frame        <= '0;
      window       <= '0;
      bits_seen    <= '0;
      timeout_flag <= 1'b0;
    end else begin
      r        <= (state == IDLE) && CS;
      ready    <= 1'b0;
      ok       <= 1'b0;
      fail     <= 1'b0;
      checkerr <= 1'b0;
      noAnswer <= 1'b0;
      busy     <= (state_d != IDLE);
      case (state)
        LOAD: begin
          // tx_bit is preloaded so W[0] is on the line in the first SEND cycle.
          frame   <= {START_BYTE, mem_read, load_csum};
          tx_bit  <= load_csum[0];
          cnt     <= '0;
          attempt <= '0;
        end
        SEND: begin
          tx_bit <= frame_sh[0];
          cnt    <= (cnt == SEND_LAST) ? '0 : cnt + 32'd1;
        end
        TURN: begin
          cnt       <= (cnt == TURN_LAST) ? '0 : cnt + 32'd1;
          window    <= '0;
          bits_seen <= '0;
        end
        RECV: begin
          window    <= window_d;
          bits_seen <= bits_d;
          cnt       <= cnt + 32'd1;
          if (rx_done) timeout_flag <= !match;
        end
        CHECK: begin
          if (finish) begin
            ready    <= 1'b1;
            ok       <= res_ok;
            fail     <= res_fail;
            checkerr <= res_cerr;
            noAnswer <= res_noans;
          end else begin
            attempt <= attempt + 1'b1;
            cnt     <= '0;
            tx_bit  <= frame[0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_master_p.sv
// Bench for serial_master_p: 16-bit instance driven from a vector table with a
// result scoreboard, plus hand sequences for reset-in-SEND and a 32-bit instance.
module tb_serial_master_p;

  localparam int TIMEOUT = 64;
  localparam int TURN    = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cs_a, cs_b;
  logic [15:0] mem_a;
  logic [31:0] mem_b;
  logic        r_a, ready_a, ok_a, fail_a, cerr_a, noans_a, busy_a;
  logic        r_b, ready_b, ok_b, fail_b, cerr_b, noans_b, busy_b;
  logic [1:0]  att_a, att_b;

  wire  sa, sb;
  logic sa_en, sa_bit, sb_en, sb_bit;
  assign sa = sa_en ? sa_bit : 1'bz;
  assign sb = sb_en ? sb_bit : 1'bz;
  pullup (sa);
  pullup (sb);

  serial_master_p #(
    .DATA_W(16), .START_BYTE(8'hAA), .MASTER_ADDR(8'h00),
    .TURNAROUND(TURN), .TIMEOUT(TIMEOUT), .MAX_RETRY(2)
  ) u_a (
    .clk(clk), .reset(rst), .serial(sa), .CS(cs_a), .mem_read(mem_a),
    .r(r_a), .ready(ready_a), .ok(ok_a), .fail(fail_a), .checkerr(cerr_a),
    .noAnswer(noans_a), .busy(busy_a), .attempt(att_a)
  );

  serial_master_p #(
    .DATA_W(32), .START_BYTE(8'hAA), .MASTER_ADDR(8'h00),
    .TURNAROUND(TURN), .TIMEOUT(TIMEOUT), .MAX_RETRY(2)
  ) u_b (
    .clk(clk), .reset(rst), .serial(sb), .CS(cs_b), .mem_read(mem_b),
    .r(r_b), .ready(ready_b), .ok(ok_b), .fail(fail_b), .checkerr(cerr_b),
    .noAnswer(noans_b), .busy(busy_b), .attempt(att_b)
  );

  // flags are {ok, fail, checkerr, noAnswer}; silent[a] selects reply_bad on attempt a
  typedef struct {
    logic [15:0] data;
    logic [7:0]  csum;
    logic [31:0] reply;
    logic [31:0] reply_bad;
    logic [2:0]  silent;
    logic [3:0]  flags;
    int          att;
  } vec_t;

  typedef struct {
    logic [3:0] flags;
    logic [1:0] att;
  } exp_t;

  exp_t sb_q[$];
  exp_t e_pop;
  vec_t vecs[8];
  int   n_vec = 0;
  int   n_miss = 0;
  int   r_cnt_a = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (r_a) r_cnt_a++;
    if (ready_a) begin
      if (sb_q.size() == 0) begin
        n_miss++;
        $display("FAIL sb_unexpected_ready: got ready=1, expected no pending result");
      end else begin
        e_pop = sb_q.pop_front();
        chk("sb_flags", {ok_a, fail_a, cerr_a, noans_a}, e_pop.flags);
        chk("sb_attempt", att_a, e_pop.att);
      end
    end else if ({ok_a, fail_a, cerr_a, noans_a} != 4'b0000) begin
      n_miss++;
      $display("FAIL flags_without_ready: got %b, expected 0000", {ok_a, fail_a, cerr_a, noans_a});
    end
  end

  // Enters at the negedge of the first SEND cycle, leaves at the negedge after CHECK.
  task automatic attempt_a(input logic [31:0] reply, input logic silent, output logic [31:0] cap);
    for (int i = 0; i < 32; i++) begin
      cap[i] = sa;
      @(negedge clk);
    end
    for (int i = 0; i < TURN; i++) begin
      chk("turn_released", sa, 1'b1);
      @(negedge clk);
    end
    sa_en = 1'b1;
    for (int j = 0; j < 32; j++) begin
      sa_bit = reply[j];
      @(negedge clk);
    end
    if (silent) begin
      sa_bit = 1'b0;
      repeat (TIMEOUT - 32) @(negedge clk);
    end
    sa_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    exp_t        e;
    logic [31:0] exp_w, cap;
    int          r0;
    e.flags = v.flags;
    e.att   = 2'(v.att);
    sb_q.push_back(e);
    r0    = r_cnt_a;
    exp_w = {8'hAA, v.data, v.csum};
    cs_a  = 1'b1;
    mem_a = v.data;
    @(negedge clk);
    chk($sformatf("v%0d_r_in_load", idx), r_a, 1'b1);
    chk($sformatf("v%0d_busy_load", idx), busy_a, 1'b1);
    cs_a = 1'b0;
    @(negedge clk);
    for (int a = 0; a <= v.att; a++) begin
      chk($sformatf("v%0d_attempt%0d_idx", idx, a), att_a, a);
      attempt_a(v.silent[a] ? v.reply_bad : v.reply, v.silent[a], cap);
      chk($sformatf("v%0d_attempt%0d_tx_frame", idx, a), cap, exp_w);
    end
    chk($sformatf("v%0d_ready_timing", idx), ready_a, 1'b1);
    chk($sformatf("v%0d_busy_end", idx), busy_a, 1'b0);
    chk($sformatf("v%0d_r_once", idx), r_cnt_a - r0, 1);
    @(negedge clk);
    chk($sformatf("v%0d_ready_one_cycle", idx), ready_a, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [47:0] cap_b;

    vecs[0] = '{16'h1234, 8'h46, 32'hAA000101, 32'h0,        3'b000, 4'b1000, 0};
    vecs[1] = '{16'h1234, 8'h46, 32'hAA000000, 32'h0,        3'b000, 4'b0100, 0};
    vecs[2] = '{16'h1234, 8'h46, 32'hAA000105, 32'h0,        3'b000, 4'b0010, 2};
    vecs[3] = '{16'hBEEF, 8'hAD, 32'hAA000101, 32'h0,        3'b001, 4'b1000, 1};
    vecs[4] = '{16'h00FF, 8'hFF, 32'hAA000202, 32'h0,        3'b000, 4'b0001, 2};
    vecs[5] = '{16'h8001, 8'h81, 32'h0,        32'h0,        3'b111, 4'b0001, 2};
    vecs[6] = '{16'hFFFF, 8'hFE, 32'hAA000101, 32'h0,        3'b000, 4'b1000, 0};
    vecs[7] = '{16'h1234, 8'h46, 32'h0,        32'hAA070101, 3'b111, 4'b0001, 2};

    rst = 1'b1; cs_a = 1'b0; cs_b = 1'b0; mem_a = '0; mem_b = '0;
    sa_en = 1'b0; sa_bit = 1'b0; sb_en = 1'b0; sb_bit = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {r_a, ready_a, ok_a, fail_a, cerr_a, noans_a, busy_a}, 7'b0);
    chk("reset_attempt", att_a, 2'd0);
    chk("reset_line_released", sa, 1'b1);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // reset while bit 10 of the frame is on the line
    cs_a = 1'b1; mem_a = 16'h1234;
    @(negedge clk);
    cs_a = 1'b0;
    @(negedge clk);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_send_outputs", {r_a, ready_a, ok_a, fail_a, cerr_a, noans_a, busy_a}, 7'b0);
    chk("rst_send_attempt", att_a, 2'd0);
    chk("rst_send_line_released", sa, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    run_vec(vecs[0], 8);

    // 32-bit payload: bytes sum to 0x200, so csum is 0x00 and the frame is 48 bits
    cs_b = 1'b1; mem_b = 32'hFF01FF01;
    @(negedge clk);
    chk("w32_r_in_load", r_b, 1'b1);
    cs_b = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 48; i++) begin
      cap_b[i] = sb;
      @(negedge clk);
    end
    chk("w32_tx_frame", cap_b, {8'hAA, 32'hFF01FF01, 8'h00});
    repeat (TURN) @(negedge clk);
    sb_en = 1'b1;
    for (int j = 0; j < 32; j++) begin
      sb_bit = 32'hAA000101 >> j;
      @(negedge clk);
    end
    sb_en = 1'b0;
    @(negedge clk);
    chk("w32_ready", ready_b, 1'b1);
    chk("w32_flags", {ok_b, fail_b, cerr_b, noans_b}, 4'b1000);
    chk("w32_attempt", att_b, 2'd0);
    chk("w32_busy_end", busy_b, 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/serial_master_p.md
Name: serial_master_p

Overview:
- Parametrised single-wire, half-duplex serial master; successor to the fixed 16-bit master.
- On CS it requests a word from memory (r/mem_read), frames it as START + data + checksum and shifts it out on the shared serial line.
- Releases the line, then hunts for the slave's 32-bit response frame under a timeout.
- Retries on error, and reports ok/fail/checkerr/noAnswer with a one-cycle ready pulse.

Parameters:
- DATA_W, 16, payload width in bits; multiple of 8, range 8..64.
- START_BYTE, 8'hAA, frame start byte.
- MASTER_ADDR, 8'h00, address this master expects in the response.
- TURNAROUND, 1, idle cycles (line released) between last TX bit and first RX sample; minimum 1.
- TIMEOUT, 64, RX cycles allowed before declaring noAnswer; minimum 32.
- MAX_RETRY, 2, re-transmissions after a failed attempt; 0 disables retry.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- serial  inout  1  shared line; driven only in SEND, high-Z otherwise.
- CS  input  1  start request; sampled only in IDLE.
- mem_read  input  DATA_W  payload; valid in the cycle r is high.
- r  output  1  one-cycle memory read strobe.
- ready  output  1  one-cycle transaction-complete pulse.
- ok  output  1  slave returned status 8'h01 (pulse with ready).
- fail  output  1  slave returned status 8'h00 (pulse with ready).
- checkerr  output  1  response checksum mismatch on final attempt (pulse with ready).
- noAnswer  output  1  timeout or unknown status on final attempt (pulse with ready).
- busy  output  1  high whenever state != IDLE.
- attempt  output  $clog2(MAX_RETRY+2)  current attempt index; 0 = first transmission.

Behaviour:
- Reset: state IDLE; all outputs 0; attempt 0; serial high-Z from the first cycle after the reset edge. Reset aborts any transfer, including mid-SEND.
- All outputs are registered. serial is the registered TX bit gated by state==SEND.
- TX frame is W = {START_BYTE, data, csum}, width FW = DATA_W+16.
  - csum = modulo-256 sum of the DATA_W/8 data bytes; this is a true sum, not XOR.
  - Bits are sent W[0] first, W[FW-1] last, one bit per clock.
- RX frame is R = {START_BYTE, addr, status, rcsum}, 32 bits, sent R[0] first.
  - The receiver shifts right: the new bit enters bit 31.
  - rcsum must equal (addr + status) mod 256.
- States:
  - IDLE:
    - CS=1 -> LOAD, with r=1 during the LOAD cycle.
    - CS is ignored in every other state; no queuing.
  - LOAD (1 cycle):
    - Latch mem_read, compute csum, build W.
    - cnt=0, attempt=0 -> SEND.
  - SEND (FW cycles):
    - Drive W[cnt]; cnt increments each cycle.
    - cnt==FW-1 -> TURN, cnt=0.
  - TURN (TURNAROUND cycles): line high-Z -> RECV.
  - RECV:
    - Shift in serial each cycle and count bits seen (saturating at 32).
    - Match when bits_seen>=32, window[31:24]==START_BYTE and window[23:16]==MASTER_ADDR -> CHECK.
    - No match within TIMEOUT cycles of entering RECV -> CHECK with a timeout flag.
  - CHECK (1 cycle), outcome by priority:
    - timeout -> noAnswer.
    - rcsum mismatch -> checkerr.
    - status==8'h01 -> ok.
    - status==8'h00 -> fail.
    - any other status -> noAnswer.
  - After CHECK:
    - ok or fail -> IDLE; ready plus that flag pulse in the next cycle.
    - checkerr or noAnswer with attempt<MAX_RETRY -> attempt+1, re-SEND the latched W. No new r; no flags.
    - checkerr or noAnswer with attempt==MAX_RETRY -> IDLE; ready plus that flag pulse in the next cycle.
- Exactly one of ok/fail/checkerr/noAnswer is high whenever ready is high; all are low otherwise.
- CS held high across ready starts a new transaction: IDLE sees CS in the cycle after ready.
- Latency, successful first attempt, CS edge to ready: 1 (LOAD) + FW + TURNAROUND + RX cycles to match + 1 (CHECK) + 1.

Test Plan:
- DATA_W=16, mem_read=16'h1234, CS pulse:
  - r high 1 cycle; serial carries W=32'hAA_1234_46, LSB first.
  - Slave replies {AA,00,01,01} -> ok+ready, attempt=0.
- Same TX, slave replies {AA,00,00,00} -> fail+ready; no retry.
- MAX_RETRY=2, slave sends bad rcsum every time:
  - 3 identical TX frames; r pulses only once.
  - Final checkerr+ready with attempt=2.
- Slave silent (line pulled low) for TIMEOUT=64 on attempt 0, then replies correctly on attempt 1 -> ok+ready, attempt=1.
- DATA_W=32, mem_read=32'hFF01FF01 -> csum=8'h00, FW=48; bit count verified.
- reset asserted at SEND bit 10 -> serial high-Z, busy=0, all flags 0 next cycle; new CS completes normally.
